layer_featuremap_streamer: RTL and testbench

LAYER_FEATUREMAP_STREAMER -- requirements
Module: layer_featuremap_streamer

---
 rtl/layer_featuremap_streamer_pkg.sv | 24 ++
 rtl/fm_skid_buffer.sv | 43 ++++
 rtl/layer_featuremap_streamer.sv | 102 ++++++++++
 tb/tb_layer_featuremap_streamer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_featuremap_streamer_pkg.sv
// layer_featuremap_streamer_pkg: shared YOLOv3-tiny streaming parameters, feature-map sizes and FSM encoding
package layer_featuremap_streamer_pkg;
    // one pixel = 32 channels x fp32, channel 0 in [31:0]
    localparam int FM_DATA_WIDTH = 1024;
    localparam int FM_ADDR_WIDTH = 14;
    localparam int FM_IMG_SIZE_L0 = 416;
    localparam int FM_IMG_SIZE_L1 = 208;
    localparam int FM_IMG_SIZE_L2 = 104;
    localparam int FM_IMG_SIZE_L3 = 52;
    localparam int FM_IMG_SIZE_L4 = 26;
    localparam int FM_IMG_SIZE_L5 = 13;
    localparam int FM_IMG_SIZE = FM_IMG_SIZE_L2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fm_state_t;

    function automatic int fm_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fm_skid_buffer.sv
// fm_skid_buffer: 2-entry valid/ready FIFO holding the head entry stable while the consumer stalls
//   Clk/Rst               clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_data   producer side
//   rd_valid/rd_ready/rd_data   consumer side, rd_data is the oldest entry
module fm_skid_buffer #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);
    logic [W-1:0] e0, e1;
    logic [1:0] cnt;
    logic push, pop;

    assign wr_ready = cnt != 2'd2;
    assign rd_valid = cnt != 2'd0;
    assign rd_data = e0;
    assign push = wr_valid && wr_ready;
    assign pop = rd_valid && rd_ready;

    // e0 is the head; e1 only fills when the head is occupied and not leaving
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt <= '0;
            e0 <= '0;
            e1 <= '0;
        end else begin
            cnt <= cnt + push - pop;
            if (pop && cnt == 2'd2)
                e0 <= e1;
            else if (push && (cnt == 2'd0 || (pop && cnt == 2'd1)))
                e0 <= wr_data;
            if (push && cnt == 2'd1 && !pop)
                e1 <= wr_data;
        end
    end
endmodule

// File: rtl/layer_featuremap_streamer.sv
// layer_featuremap_streamer: reads one IMG_SIZE x IMG_SIZE frame from memory and streams it in raster order
//   Clk/Rst                      clock, synchronous active-low reset
//   start/base_addr              frame request, base latched when accepted in IDLE
//   mem_rd_en/mem_addr/mem_rd_data  memory read port, data returns one cycle after mem_rd_en
//   data_out/valid_out/ready_in  pixel stream with eol_out/eof_out row/frame markers
//   busy/done                    frame in progress, one-cycle completion pulse
module layer_featuremap_streamer
    import layer_featuremap_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = FM_DATA_WIDTH,
    parameter int IMG_SIZE = FM_IMG_SIZE,
    parameter int ADDR_WIDTH = FM_ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  eol_out,
    output logic                  eof_out,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = fm_cnt_width(IMG_SIZE);
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    fm_state_t state, state_nx;
    logic [CW-1:0] col, row;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0] pend;
    logic [1:0] tag;
    logic inflight, pop, last_rd, wr_ready;
    logic [DATA_WIDTH+1:0] head;

    assign pop = valid_out && ready_in;
    assign last_rd = (col == LAST) && (row == LAST);
    // pend = buffered + in flight; a read is allowed if the total after this cycle stays within 2
    assign mem_rd_en = (state == RUN) && (pend < 2'd2 || pop);
    assign mem_addr = addr;
    assign {eol_out, eof_out, data_out} = head;

    always_ff @(posedge Clk) begin
        if (!Rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy = state != IDLE;
        done = state == DONE;
        state_nx = state == IDLE  ? (start ? RUN : IDLE) :
                   state == RUN   ? (mem_rd_en && last_rd ? DRAIN : RUN) :
                   state == DRAIN ? (pop && eof_out ? DONE : DRAIN) : IDLE;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            col <= '0;
            row <= '0;
            addr <= '0;
            pend <= '0;
            tag <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            pend <= pend + mem_rd_en - pop;
            // eol/eof are decided at issue time and follow the data into the buffer
            if (mem_rd_en)
                tag <= {col == LAST, last_rd};
            if (state == IDLE && start) begin
                addr <= base_addr;
                col <= '0;
                row <= '0;
            end else if (mem_rd_en) begin
                addr <= addr + 1'b1;
                col <= (col == LAST) ? '0 : col + 1'b1;
                if (col == LAST)
                    row <= row + 1'b1;
            end
        end
    end

    fm_skid_buffer #(
        .W(DATA_WIDTH + 2)
    ) u_buf (
        .Clk(Clk),
        .Rst(Rst),
        .wr_valid(inflight && wr_ready),
        .wr_ready(wr_ready),
        .wr_data({tag, mem_rd_data}),
        .rd_valid(valid_out),
        .rd_ready(ready_in),
        .rd_data(head)
    );
endmodule

// File: tb/tb_layer_featuremap_streamer.sv
// tb_layer_featuremap_streamer: directed and randomized frames checked against a frame-level reference model
module tb_layer_featuremap_streamer;
    localparam int DW = 1024;
    localparam int AW = 14;
    localparam int N = 4;
    localparam int NPIX = N * N;

    logic Clk, Rst, start, ready_in;
    logic [AW-1:0] base_addr, mem_addr;
    logic mem_rd_en, valid_out, eol_out, eof_out, busy, done;
    logic [DW-1:0] mem_rd_data, data_out;

    int n_pass = 0, n_total = 0;
    int rmode, frames_done, issued, acc, cyc, bubbles, first_rd, first_x, last_x;
    logic mon_on, m_busy, m_done, prev_stall;
    logic [AW-1:0] m_base;
    logic [63:0] held_d;
    logic [1:0] held_t;

    layer_featuremap_streamer #(.DATA_WIDTH(DW), .IMG_SIZE(N), .ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .eol_out(eol_out), .eof_out(eof_out), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    // memory: every channel of a word holds its own address; junk when not read
    always @(posedge Clk)
        mem_rd_data <= mem_rd_en ? {32{32'(mem_addr)}} : {32{32'hDEADBEEF}};

    function automatic logic [63:0] decode(input logic [DW-1:0] d);
        for (int i = 1; i < 32; i++)
            if (d[32*i +: 32] !== d[31:0]) return {32'hBAD0BAD0, d[31:0]};
        return {32'h0, d[31:0]};
    endfunction

    function automatic logic [63:0] addr_of(input int k);
        return 64'(AW'(32'(m_base) + k));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic monitor();
        logic xfer;
        xfer = valid_out && ready_in;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        if (!m_busy || m_done) begin
            chk("idle_valid", 64'(valid_out), 64'(0));
            chk("idle_rd", 64'(mem_rd_en), 64'(0));
        end
        if (Rst && m_busy && !m_done) begin
            if (mem_rd_en) begin
                chk("rd_addr", 64'(mem_addr), addr_of(issued));
                issued++;
                if (issued == 1) first_rd = cyc;
                chk("outstanding_le2", 64'((issued - acc - int'(xfer)) <= 2), 64'(1));
            end
            if (valid_out && prev_stall) begin
                chk("hold_data", decode(data_out), held_d);
                chk("hold_tag", 64'({eol_out, eof_out}), 64'(held_t));
            end
            if (xfer) begin
                chk("pix", decode(data_out), addr_of(acc));
                chk("eol", 64'(eol_out), 64'(acc % N == N - 1));
                chk("eof", 64'(eof_out), 64'(acc == NPIX - 1));
                if (acc == 0) first_x = cyc;
                last_x = cyc;
                acc++;
            end else if (ready_in && acc > 0) bubbles++;
            prev_stall = valid_out && !ready_in;
            held_d = decode(data_out);
            held_t = {eol_out, eof_out};
        end else prev_stall = 1'b0;
        if (!Rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
            frames_done++;
            chk("reads_per_frame", 64'(issued), 64'(NPIX));
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_base = base_addr;
                issued = 0;
                acc = 0;
                cyc = 0;
                bubbles = 0;
            end
        end else if (acc == NPIX) m_done = 1'b1;
        if (m_busy) cyc++;
    endtask

    task automatic tick();
        @(negedge Clk);
        if (mon_on) monitor();
        @(posedge Clk);
        #1;
        ready_in = rmode == 0 ? 1'b1 : rmode == 1 ? ~ready_in :
                   rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        chk("frame_timeout", 64'(frames_done), 64'(target));
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        Clk = 0; Rst = 0; start = 0; base_addr = '0; ready_in = 0; rmode = 3; mon_on = 0;
        m_busy = 0; m_done = 0; prev_stall = 0; m_base = '0; held_d = '0; held_t = '0;
        frames_done = 0; issued = 0; acc = 0; cyc = 0; bubbles = 0; first_rd = 0; first_x = 0; last_x = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_valid", 64'(valid_out), 64'(0));
        chk("rst_rd_en", 64'(mem_rd_en), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_eol", 64'(eol_out), 64'(0));
        chk("rst_eof", 64'(eof_out), 64'(0));
        chk("rst_data", decode(data_out), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        Rst = 1; mon_on = 1;
        tick(); tick();

        // full-rate frame: latency and throughput
        rmode = 0; ready_in = 1;
        pulse_start(14'h10);
        wait_frames(1, 60);
        chk("first_rd_cyc", 64'(first_rd), 64'(1));
        chk("first_xfer_cyc", 64'(first_x), 64'(3));
        chk("last_xfer_cyc", 64'(last_x), 64'(3 + NPIX - 1));
        chk("bubbles_full", 64'(bubbles), 64'(0));
        tick();

        // long stall right after start
        rmode = 3; ready_in = 0;
        pulse_start(14'h10);
        repeat (20) tick();
        chk("stall_reads", 64'(issued), 64'(2));
        chk("stall_head", decode(data_out), 64'h10);
        rmode = 0; ready_in = 1;
        wait_frames(2, 60);
        chk("bubbles_release", 64'(bubbles), 64'(0));

        // alternating ready
        rmode = 1;
        pulse_start(AW'($urandom));
        wait_frames(3, 100);

        // random ready, random bases
        for (int f = 0; f < 4; f++) begin
            rmode = 2;
            pulse_start(AW'($urandom));
            wait_frames(4 + f, 300);
        end

        // address wrap
        rmode = 0;
        pulse_start(14'h3FFD);
        wait_frames(8, 60);

        // reset while stalled on pixel 7
        rmode = 0;
        pulse_start(AW'($urandom));
        for (int n = 0; acc < 7 && n < 50; n++) tick();
        chk("reach_pix7", 64'(acc), 64'(7));
        rmode = 3; ready_in = 0;
        tick(); tick();
        Rst = 0;
        tick();
        Rst = 1;
        chk("abort_valid", 64'(valid_out), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_data", decode(data_out), 64'(0));
        repeat (3) tick();
        rmode = 0;
        pulse_start(14'h20);
        wait_frames(9, 60);

        // reset with reads in flight
        rmode = 0;
        pulse_start(AW'($urandom));
        for (int n = 0; issued < 6 && n < 50; n++) tick();
        Rst = 0;
        tick();
        Rst = 1;
        repeat (4) tick();
        rmode = 2;
        pulse_start(AW'($urandom));
        wait_frames(10, 300);

        // start held through two frames
        rmode = 2;
        base_addr = AW'($urandom);
        start = 1;
        wait_frames(12, 600);
        start = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
